// File: rtl/intfac_trialdiv_seq_if.sv
// Host and remainder-engine signal bundle for the trial-division sequencer.
// The master modport is the host/engine side; the slave modport is the sequencer.
interface intfac_trialdiv_seq_if #(
  parameter int DW = 22,
  parameter int VW = 4
);
  logic          start;
  logic [DW-1:0] n;
  logic [VW-1:0] factor;
  logic          factor_found;
  logic          incomplete;
  logic          result_ready;
  logic          rem_start;
  logic [DW-1:0] rem_dividend;
  logic [VW-1:0] rem_orgdiv;
  logic [VW-1:0] rem_result;
  logic          rem_ready;

  modport master (
    output start, n, rem_result, rem_ready,
    input  factor, factor_found, incomplete, result_ready,
    input  rem_start, rem_dividend, rem_orgdiv
  );

  modport slave (
    input  start, n, rem_result, rem_ready,
    output factor, factor_found, incomplete, result_ready,
    output rem_start, rem_dividend, rem_orgdiv
  );
endinterface

// File: rtl/intfac_trialdiv_seq.sv
// Trial-division sequencer: drives one remainder engine with d = 2..MAXDIV and reports the smallest factor.
// Optional macro INTFAC_EVEN_SHORTCUT_EN resolves even numbers from bit 0 instead of dividing by 2.
module intfac_trialdiv_seq #(
  parameter int DW     = 22,
  parameter int VW     = 4,
  parameter int MAXDIV = 15
) (
  input logic                 clk,
  input logic                 reset,
  intfac_trialdiv_seq_if.slave bus
);
  localparam int SW = 2 * (VW + 1);
  localparam int MW = (SW > DW) ? SW : DW;

  localparam logic [VW:0]   D_TWO    = (VW + 1)'(2);
  localparam logic [VW:0]   D_THREE  = (VW + 1)'(3);
  localparam logic [VW:0]   D_ONE    = (VW + 1)'(1);
  localparam logic [VW:0]   MAXDIV_W = (VW + 1)'(MAXDIV);
  localparam logic [DW-1:0] N_TWO    = DW'(2);
  localparam logic [DW-1:0] N_FOUR   = DW'(4);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_ISSUE  = 3'd2,
    S_SETTLE = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] nreg_q, nreg_d;
  logic [VW:0]   d_q, d_d;
  logic [VW-1:0] factor_q, factor_d;
  logic          found_q, found_d;
  logic          incomplete_q, incomplete_d;
  logic          rem_start_q, rem_start_d;
  logic [VW-1:0] rem_orgdiv_q, rem_orgdiv_d;

  logic [SW-1:0] d_sq_s;
  logic [MW-1:0] d_sq_w_s;
  logic [MW-1:0] nreg_w_s;

  // d is VW+1 bits so d*d needs 2*(VW+1); both sides are zero-extended to a common width
  assign d_sq_s   = SW'(d_q) * SW'(d_q);
  assign d_sq_w_s = MW'(d_sq_s);
  assign nreg_w_s = MW'(nreg_q);

  always_comb begin
    state_d      = state_q;
    nreg_d       = nreg_q;
    d_d          = d_q;
    factor_d     = factor_q;
    found_d      = found_q;
    incomplete_d = incomplete_q;
    rem_start_d  = rem_start_q;
    rem_orgdiv_d = rem_orgdiv_q;

    if (bus.start) begin
      // a start in any state aborts the current job
      nreg_d       = bus.n;
      d_d          = D_TWO;
      factor_d     = '0;
      found_d      = 1'b0;
      incomplete_d = 1'b0;
      rem_start_d  = 1'b0;
      state_d      = S_CHECK;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_CHECK: begin
          if (nreg_q < N_TWO) begin
            state_d = S_DONE;
          end else if (d_q > MAXDIV_W) begin
            incomplete_d = 1'b1;
            state_d      = S_DONE;
          end
`ifdef INTFAC_EVEN_SHORTCUT_EN
          else if ((d_q == D_TWO) && !nreg_q[0] && (nreg_q >= N_FOUR)) begin
            factor_d = D_TWO[VW-1:0];
            found_d  = 1'b1;
            state_d  = S_DONE;
          end else if ((d_q == D_TWO) && nreg_q[0]) begin
            d_d = D_THREE;
          end
`endif
          else if (d_sq_w_s > nreg_w_s) begin
            state_d = S_DONE;
          end else begin
            rem_orgdiv_d = d_q[VW-1:0];
            rem_start_d  = 1'b1;
            state_d      = S_ISSUE;
          end
        end
        S_ISSUE: begin
          rem_start_d = 1'b0;
          state_d     = S_SETTLE;
        end
        S_SETTLE: begin
          // engine is still in its init state here, so its ready flag is not trusted yet
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (bus.rem_ready) begin
            if (bus.rem_result == '0) begin
              factor_d = d_q[VW-1:0];
              found_d  = 1'b1;
              state_d  = S_DONE;
            end else begin
              d_d     = d_q + D_ONE;
              state_d = S_CHECK;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      nreg_q       <= '0;
      d_q          <= D_TWO;
      factor_q     <= '0;
      found_q      <= 1'b0;
      incomplete_q <= 1'b0;
      rem_start_q  <= 1'b0;
      rem_orgdiv_q <= '0;
    end else begin
      state_q      <= state_d;
      nreg_q       <= nreg_d;
      d_q          <= d_d;
      factor_q     <= factor_d;
      found_q      <= found_d;
      incomplete_q <= incomplete_d;
      rem_start_q  <= rem_start_d;
      rem_orgdiv_q <= rem_orgdiv_d;
    end
  end

  assign bus.factor       = factor_q;
  assign bus.factor_found = found_q;
  assign bus.incomplete   = incomplete_q;
  assign bus.result_ready = (state_q == S_IDLE) & ~bus.start;
  assign bus.rem_start    = rem_start_q;
  assign bus.rem_dividend = nreg_q;
  assign bus.rem_orgdiv   = rem_orgdiv_q;
endmodule

// File: tb/tb_intfac_trialdiv_seq.sv
// Scoreboard bench for intfac_trialdiv_seq with a behavioural remainder engine.
module tb_intfac_trialdiv_seq;
  localparam int DW  = 22;
  localparam int VW  = 4;
  localparam int LAT = 5;
`ifdef INTFAC_EVEN_SHORTCUT_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic clk;
  logic reset;
  intfac_trialdiv_seq_if #(.DW(DW), .VW(VW)) bus ();

  intfac_trialdiv_seq #(.DW(DW), .VW(VW), .MAXDIV(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // remainder engine model: busy for LAT cycles after a start, result forced to 0 while busy
  logic          eng_busy;
  int            eng_cnt;
  logic [VW-1:0] eng_res;
  logic [DW-1:0] eng_n;
  logic [VW-1:0] eng_div;
  logic          ovr_en, ovr_ready;

  always @(posedge clk) begin
    if (bus.rem_start) begin
      eng_busy <= 1'b1;
      eng_cnt  <= LAT;
      eng_n    <= bus.rem_dividend;
      eng_div  <= bus.rem_orgdiv;
    end else if (eng_busy) begin
      if (eng_cnt == 1) begin
        eng_busy <= 1'b0;
        eng_res  <= VW'(eng_n % DW'(eng_div));
      end
      eng_cnt <= eng_cnt - 1;
    end
  end

  assign bus.rem_ready  = ovr_en ? ovr_ready : (~eng_busy & ~bus.rem_start);
  assign bus.rem_result = ovr_en ? '0 : (eng_busy ? '0 : eng_res);

  int pulse_cnt;
  always @(posedge clk) begin
    if (reset || bus.start) pulse_cnt <= 0;
    else if (bus.rem_start) pulse_cnt <= pulse_cnt + 1;
  end

  typedef struct {
    logic [VW-1:0] f;
    logic          fd;
    logic          inc;
    int            pulses;
    int            maxlat;
    int            org;
    string         name;
  } exp_t;

  exp_t q[$];
  int   checks, errors, done_cnt;
  int   probe_req, probe_seen, tmo_req, tmo_seen, lat;
  logic prev_rr;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic compare_item(input exp_t e);
    chk({e.name, ".factor"}, int'(bus.factor), int'(e.f));
    chk({e.name, ".found"}, int'(bus.factor_found), int'(e.fd));
    chk({e.name, ".incomplete"}, int'(bus.incomplete), int'(e.inc));
    chk({e.name, ".pulses"}, pulse_cnt, e.pulses);
    if (e.maxlat > 0) chk({e.name, ".latency_ok"}, int'(lat <= e.maxlat), 1);
    if (e.org >= 0) begin
      chk({e.name, ".orgdiv"}, int'(bus.rem_orgdiv), e.org);
      chk({e.name, ".rem_start"}, int'(bus.rem_start), 0);
    end
  endtask

  // monitor: compares on each result_ready rise and on explicit probe requests
  always @(negedge clk) begin
    if (bus.start === 1'b1) lat = 0;
    else lat = lat + 1;
    if (bus.result_ready === 1'b1 && prev_rr !== 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        compare_item(q.pop_front());
      end
      done_cnt++;
    end
    if (probe_req != probe_seen) begin
      probe_seen = probe_req;
      chk("probe.result_ready", int'(bus.result_ready === 1'b1), 1);
      if (q.size() == 0) chk("probe_empty", 1, 0);
      else compare_item(q.pop_front());
    end
    if (tmo_req != tmo_seen) begin
      tmo_seen = tmo_req;
      chk("timeout", 1, 0);
    end
    prev_rr = bus.result_ready;
  end

  function automatic exp_t mk(input logic [DW-1:0] nv, input int f, input bit fd, input bit inc,
                              input int p, input int maxlat, input int org, input string nm);
    exp_t e;
    e.f = VW'(f);
    e.fd = fd;
    e.inc = inc;
    e.pulses = p;
    if (SC && nv >= 4) e.pulses = nv[0] ? p - 1 : 0;
    e.maxlat = maxlat;
    e.org = org;
    e.name = nm;
    return e;
  endfunction

  task automatic pulse_start(input logic [DW-1:0] nv);
    @(posedge clk); #1;
    bus.n = nv;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int k = 0;
    while (done_cnt == base && k < 2000) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt == base) tmo_req++;
    #1;
  endtask

  task automatic wait_org3();
    int k = 0;
    while (bus.rem_orgdiv != VW'(3) && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    if (bus.rem_orgdiv != VW'(3)) tmo_req++;
    repeat (3) @(posedge clk);
  endtask

  task automatic run_job(input logic [DW-1:0] nv, input int f, input bit fd, input bit inc,
                         input int p, input int maxlat, input string nm);
    int base;
    q.push_back(mk(nv, f, fd, inc, p, maxlat, -1, nm));
    base = done_cnt;
    pulse_start(nv);
    wait_done(base);
  endtask

  initial begin
    int base;
    checks = 0; errors = 0; done_cnt = 0; probe_req = 0; probe_seen = 0;
    tmo_req = 0; tmo_seen = 0; lat = 0;
    eng_busy = 1'b0; eng_cnt = 0; eng_res = '0; eng_n = '0; eng_div = '0;
    ovr_en = 1'b0; ovr_ready = 1'b0;
    bus.start = 1'b0; bus.n = '0;
    reset = 1'b1;
    q.push_back(mk('0, 0, 0, 0, 0, 0, 0, "reset"));
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    run_job(22'd91, 7, 1, 0, 6, 0, "n91");
    run_job(22'd97, 0, 0, 0, 8, 0, "n97");
    run_job(22'd289, 0, 0, 1, 14, 0, "n289");
    run_job(22'd257, 0, 0, 1, 14, 0, "n257");
    run_job(22'd0, 0, 0, 0, 0, 3, "n0");
    run_job(22'd1, 0, 0, 0, 0, 3, "n1");
    run_job(22'd2, 0, 0, 0, 0, 0, "n2");
    run_job(22'd3, 0, 0, 0, 0, 0, "n3");
    run_job(22'd4, 2, 1, 0, 1, 0, "n4");
    run_job(22'd1000, 2, 1, 0, 1, 0, "n1000");
    run_job(22'd169, 13, 1, 0, 12, 0, "n169");
    run_job(22'd4194303, 3, 1, 0, 2, 0, "nmax");

    // abort n=91 while waiting on d=3, restart with n=35
    q.push_back(mk(22'd35, 5, 1, 0, 4, 0, -1, "restart35"));
    base = done_cnt;
    pulse_start(22'd91);
    wait_org3();
    pulse_start(22'd35);
    wait_done(base);

    // reset mid-WAIT, then rem_ready toggles while idle must be ignored
    base = done_cnt;
    pulse_start(22'd91);
    wait_org3();
    q.push_back(mk('0, 0, 0, 0, 0, 0, 0, "midreset"));
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    wait_done(base);
    ovr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ovr_ready = ~ovr_ready;
      @(posedge clk); #1;
    end
    q.push_back(mk('0, 0, 0, 0, 0, 0, 0, "toggles"));
    probe_req++;
    @(posedge clk); #1;
    ovr_en = 1'b0;

    run_job(22'd25, 5, 1, 0, 4, 0, "n25");
    repeat (3) @(posedge clk);
    if (q.size() != 0) tmo_req++;
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
